// File: rtl/mert_to_mont.sv
// Montgomery-domain entry converter: R = (A * 2^K) mod Q by iterative modular doubling,
// S doublings per clock, one operation in flight with valid/ready on both sides.
module mert_to_mont #(
  parameter logic [31:0] Q = 32'd2181040129,
  parameter int unsigned K = 33,
  parameter int unsigned S = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] R,
  output logic        busy
);

  localparam int unsigned STEPS = K / S;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);
  localparam logic [32:0]   Q_EXT = {1'b0, Q};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [31:0]     x;
  logic [CW-1:0]   cnt;
  logic [31:0]     a_red;
  logic [31:0]     x_next;
  logic [32:0]     t;

  // A single conditional subtraction suffices since 2^32 < 2Q.
  always_comb a_red = (A >= Q) ? A - Q : A;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    x_next = x;
    t      = '0;
    for (int i = 0; i < int'(S); i++) begin
      // Compare on the full 33-bit doubled value; x < Q keeps t - Q below 2^32.
      t      = {x_next, 1'b0};
      x_next = (t >= Q_EXT) ? 32'(t - Q_EXT) : t[31:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x     <= a_red;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          x   <= x_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign R         = x;

endmodule

// File: tb/tb_mert_to_mont.sv
// Bench for mert_to_mont: four instances (S = 1, 3, 11, 33) checked against a
// modular-arithmetic reference model with random and boundary operands.
module tb_mert_to_mont;

  localparam longint unsigned QM = 64'd2181040129;
  localparam int SV [4] = '{1, 3, 11, 33};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [3:0][31:0] a;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [3:0][31:0] dut_r;
  logic [3:0]       busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mert_to_mont #(.S(SV[g])) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .A        (a[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .R        (dut_r[g]),
      .busy     (busy[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // (A mod Q) * 2^33 mod Q, taken as three multiplications by 2^11.
  function automatic logic [31:0] golden(input logic [31:0] av);
    longint unsigned r;
    r = longint'(av) % QM;
    for (int i = 0; i < 3; i++) r = (r << 11) % QM;
    return 32'(r);
  endfunction

  // Hand one operand to instance d and wait for its result.
  task automatic convert(input int d, input logic [31:0] av, output logic [31:0] r,
                         output int lat, output bit ready_low);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready[d] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", in_ready[d], 1);
    in_valid[d] = 1'b1;
    a[d]        = av;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    a[d]        = $urandom;
    lat       = 0;
    ready_low = 1'b1;
    while (!out_valid[d] && lat < 200) begin
      if (in_ready[d]) ready_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    r = dut_r[d];
  endtask

  initial begin
    logic [31:0] r, r_hold, exp;
    logic [31:0] vec [1000];
    logic [31:0] sweep [8];
    logic [31:0] exp_q [$];
    int lat;
    bit rl, seen;
    int acc_i, res_i, cyc, last_acc, stalls;

    in_valid  = '0;
    out_ready = '1;
    for (int i = 0; i < 4; i++) a[i] = '0;

    #2;
    check("rst_in_ready", in_ready[0], 1);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_r", dut_r[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a run.
    @(negedge clk);
    in_valid[0] = 1'b1;
    a[0] = 32'd1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    check("mid_busy", busy[0], 1);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready[0], 1);
    check("mid_rst_out_valid", out_valid[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_r", dut_r[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid[0] || busy[0]) seen = 1'b1;
    end
    check("mid_no_out_valid", seen, 0);
    convert(0, 32'd2, r, lat, rl);
    check("mid_a2_r", r, 32'd1912588281);

    // Basic vectors and input reduction on S=1.
    sweep = '{32'd0, 32'd1, 32'd2, 32'd2181040129, 32'd2181040130, 32'hFFFFFFFF,
              32'd2181040128, $urandom};
    convert(0, sweep[0], r, lat, rl);
    check("a0_r", r, 0);
    check("a0_lat", lat, 33);
    check("a0_ready_low", rl, 1);
    convert(0, sweep[1], r, lat, rl);
    check("a1_r", r, 32'd2046814205);
    check("a1_lat", lat, 33);
    check("a1_ready_low", rl, 1);
    convert(0, sweep[2], r, lat, rl);
    check("a2_r", r, 32'd1912588281);
    convert(0, sweep[3], r, lat, rl);
    check("aq_r", r, 0);
    convert(0, sweep[4], r, lat, rl);
    check("aq1_r", r, 32'd2046814205);
    convert(0, sweep[5], r, lat, rl);
    check("amax_r", r, golden(sweep[5]));
    @(posedge clk);
    #1;
    check("a_done_idle", in_ready[0], 1);

    // Backpressure: DONE holds while in_valid and A toggle.
    out_ready[0] = 1'b0;
    exp = $urandom;
    convert(0, exp, r_hold, lat, rl);
    check("bp_r", r_hold, golden(exp));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid[0] = 1'($urandom);
      a[0]        = $urandom;
      check("bp_r_stable", dut_r[0], r_hold);
      check("bp_in_ready", in_ready[0], 0);
      check("bp_out_valid", out_valid[0], 1);
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", in_ready[0], 1);
    check("bp_release_busy", busy[0], 0);

    // Back-to-back with in_valid held high and random out_ready.
    for (int i = 0; i < 1000; i++) vec[i] = $urandom;
    vec[0] = 32'd0;
    vec[1] = 32'd2181040128;
    vec[2] = 32'd2181040129;
    vec[3] = 32'hFFFFFFFF;
    acc_i = 0; res_i = 0; cyc = 0; last_acc = -1; stalls = 0;
    while (res_i < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (acc_i < 1000) begin
        in_valid[0] = 1'b1;
        a[0] = vec[acc_i];
      end else begin
        in_valid[0] = 1'b0;
      end
      out_ready[0] = ($urandom_range(0, 3) != 0);
      if (in_valid[0] && in_ready[0]) begin
        if (last_acc >= 0) check("b2b_interval", cyc - last_acc, 35 + stalls);
        last_acc = cyc;
        stalls = 0;
        exp_q.push_back(golden(vec[acc_i]));
        acc_i++;
      end
      if (out_valid[0]) begin
        if (out_ready[0]) begin
          check("b2b_pending", exp_q.size(), 1);
          if (exp_q.size() > 0) check("b2b_r", dut_r[0], exp_q.pop_front());
          res_i++;
        end else begin
          stalls++;
        end
      end
    end
    check("b2b_count", res_i, 1000);
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;

    // Parameter sweep: same vectors through S = 3, 11, 33.
    for (int d = 1; d < 4; d++) begin
      for (int i = 0; i < 8; i++) begin
        convert(d, sweep[i], r, lat, rl);
        check($sformatf("sweep_s%0d_r", SV[d]), r, golden(sweep[i]));
        check($sformatf("sweep_s%0d_lat", SV[d]), lat, 33 / SV[d]);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
